// File: rtl/passcode_decoder.sv
// Passcode symbol decoder: maps 5-bit symbols to BCD digits, assembles DIGITS-digit
// frames and hands them downstream over a valid/ready handshake.
module passcode_decoder #(
  parameter int DIGITS  = 4,
  parameter int TIMEOUT = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic [4:0]                   code_in,
  input  logic                         code_valid,
  output logic                         code_ready,
  output logic [4*DIGITS-1:0]          digits_out,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(DIGITS+1)-1:0]  digit_cnt,
  output logic                         err,
  output logic                         timeout
);

  localparam int CW = $clog2(DIGITS + 1);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TLAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t              state_q, state_d;
  logic [4*DIGITS-1:0] data_q, data_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [TW-1:0]       idle_q, idle_d;
  logic                err_q, err_d;
  logic                to_q, to_d;

  logic                accept;
  logic                legal;
  logic [3:0]          digit;
  logic [CW-1:0]       cnt_inc;
  logic [4*DIGITS-1:0] digit_ext;

  // Returns {legal, digit}
  function automatic logic [4:0] decode(input logic [4:0] code);
    case (code)
      5'b00000: decode = {1'b1, 4'd0};
      5'b00001: decode = {1'b1, 4'd1};
      5'b10001: decode = {1'b1, 4'd2};
      5'b10010: decode = {1'b1, 4'd3};
      5'b01010: decode = {1'b1, 4'd4};
      5'b01011: decode = {1'b1, 4'd5};
      5'b11011: decode = {1'b1, 4'd6};
      5'b11111: decode = {1'b1, 4'd7};
      5'b01111: decode = {1'b1, 4'd8};
      5'b01110: decode = {1'b1, 4'd9};
      default:  decode = 5'b0_0000;
    endcase
  endfunction

  assign {legal, digit} = decode(code_in);
  assign code_ready     = (state_q != DONE) && !clear;
  assign accept         = code_valid && code_ready;
  assign cnt_inc        = cnt_q + CW'(1);

  always_comb begin
    digit_ext      = '0;
    digit_ext[3:0] = digit;
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    idle_d  = idle_q;
    err_d   = 1'b0;
    to_d    = 1'b0;
    if (clear) begin
      state_d = IDLE;
      data_d  = '0;
      cnt_d   = '0;
      idle_d  = '0;
    end else begin
      case (state_q)
        IDLE, COLLECT: begin
          if (accept) begin
            idle_d = '0;
            if (legal) begin
              data_d  = (data_q << 4) | digit_ext;
              cnt_d   = cnt_inc;
              state_d = (cnt_inc == CW'(DIGITS)) ? DONE : COLLECT;
            end else begin
              err_d   = 1'b1;
              data_d  = '0;
              cnt_d   = '0;
              state_d = IDLE;
            end
          end else if (state_q == COLLECT && TIMEOUT > 0) begin
            // An accept on the terminal cycle takes the branch above, so it wins.
            if (idle_q == TLAST) begin
              to_d    = 1'b1;
              data_d  = '0;
              cnt_d   = '0;
              idle_d  = '0;
              state_d = IDLE;
            end else begin
              idle_d = idle_q + TW'(1);
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
            data_d  = '0;
            cnt_d   = '0;
            idle_d  = '0;
          end
        end
        default: begin
          state_d = IDLE;
          data_d  = '0;
          cnt_d   = '0;
          idle_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      idle_q  <= '0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
      err_q   <= err_d;
      to_q    <= to_d;
    end
  end

  // out_valid decodes state directly so an async reset drops it without a clock
  assign out_valid  = (state_q == DONE);
  assign digits_out = data_q;
  assign digit_cnt  = cnt_q;
  assign err        = err_q;
  assign timeout    = to_q;

endmodule

// File: tb/tb_passcode_decoder.sv
// Directed bench for passcode_decoder with DIGITS=4, TIMEOUT=8.
module tb_passcode_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic [4:0]  code_in;
  logic        code_valid;
  logic        code_ready;
  logic [15:0] digits_out;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  digit_cnt;
  logic        err;
  logic        timeout;

  int n_chk = 0;
  int n_err = 0;

  logic [4:0] leg [10] = '{5'b00000, 5'b00001, 5'b10001, 5'b10010, 5'b01010,
                           5'b01011, 5'b11011, 5'b11111, 5'b01111, 5'b01110};

  passcode_decoder #(.DIGITS(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .code_in(code_in), .code_valid(code_valid), .code_ready(code_ready),
    .digits_out(digits_out), .out_valid(out_valid), .out_ready(out_ready),
    .digit_cnt(digit_cnt), .err(err), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [4:0] c);
    code_in    = c;
    code_valid = 1'b1;
    tick();
    code_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic frame(input logic [4:0] a, b, c, d, input logic [15:0] exp, input string tag);
    send(a); send(b); send(c); send(d);
    chk({tag, "_data"}, digits_out, exp);
    chk({tag, "_valid"}, out_valid, 1);
    drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; clear = 1'b0; code_in = '0; code_valid = 1'b0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_data", digits_out, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_cnt", digit_cnt, 0);
    chk("rst_err", err, 0);
    chk("rst_to", timeout, 0);
    rst_n = 1'b1;
    tick();
    chk("rst_ready", code_ready, 1);

    // Basic frame 2345
    send(5'b10001); send(5'b10010); send(5'b01010);
    chk("t1_cnt3", digit_cnt, 3);
    chk("t1_nvalid", out_valid, 0);
    send(5'b01011);
    chk("t1_valid", out_valid, 1);
    chk("t1_data", digits_out, 16'h2345);
    chk("t1_cnt", digit_cnt, 4);
    chk("t1_ready", code_ready, 0);

    // Backpressure in DONE
    code_in = 5'b00001; code_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_data", digits_out, 16'h2345);
      chk("t2_ready", code_ready, 0);
      chk("t2_cnt", digit_cnt, 4);
    end
    code_valid = 1'b0;
    drain();
    chk("t2_valid", out_valid, 0);
    chk("t2_data0", digits_out, 0);
    chk("t2_cnt0", digit_cnt, 0);
    chk("t2_ready1", code_ready, 1);

    // All legal codes
    frame(leg[0], leg[1], leg[2], leg[3], 16'h0123, "t3a");
    frame(leg[4], leg[5], leg[6], leg[7], 16'h4567, "t3b");
    frame(leg[8], leg[9], leg[0], leg[1], 16'h8901, "t3c");

    // All illegal codes from IDLE
    for (int c = 0; c < 32; c++) begin
      logic is_leg;
      is_leg = 1'b0;
      for (int k = 0; k < 10; k++) if (leg[k] == 5'(c)) is_leg = 1'b1;
      if (!is_leg) begin
        send(5'(c));
        chk("t3_err", err, 1);
        chk("t3_cnt", digit_cnt, 0);
        tick();
        chk("t3_err0", err, 0);
      end
    end

    // Illegal symbol mid-frame
    send(5'b00001); send(5'b10001);
    chk("t4_cnt2", digit_cnt, 2);
    send(5'b00011);
    chk("t4_err", err, 1);
    chk("t4_cnt", digit_cnt, 0);
    chk("t4_data", digits_out, 0);
    chk("t4_to", timeout, 0);
    tick();
    chk("t4_err0", err, 0);
    frame(5'b00000, 5'b00000, 5'b00000, 5'b01110, 16'h0009, "t4b");

    // Timeout after 8 idle cycles
    send(5'b00001);
    chk("t5_cnt1", digit_cnt, 1);
    for (int i = 0; i < 7; i++) tick();
    chk("t5_to_early", timeout, 0);
    chk("t5_cnt_hold", digit_cnt, 1);
    tick();
    chk("t5_to", timeout, 1);
    chk("t5_cnt0", digit_cnt, 0);
    chk("t5_data0", digits_out, 0);
    chk("t5_err", err, 0);
    tick();
    chk("t5_to0", timeout, 0);

    // Accept on the terminal cycle beats timeout
    send(5'b00001);
    for (int i = 0; i < 7; i++) tick();
    send(5'b10001);
    chk("t5b_to", timeout, 0);
    chk("t5b_cnt", digit_cnt, 2);
    chk("t5b_data", digits_out, 16'h0012);
    tick();
    chk("t5b_to1", timeout, 0);

    // clear with code_valid in COLLECT
    code_in = 5'b00001; code_valid = 1'b1; clear = 1'b1;
    #1;
    chk("t6_ready", code_ready, 0);
    tick();
    clear = 1'b0; code_valid = 1'b0;
    chk("t6_cnt", digit_cnt, 0);
    chk("t6_data", digits_out, 0);
    chk("t6_err", err, 0);
    chk("t6_to", timeout, 0);

    // clear drops a pending frame
    send(5'b11011); send(5'b11011); send(5'b11011); send(5'b11011);
    chk("t6b_valid", out_valid, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t6b_drop", out_valid, 0);
    chk("t6b_data", digits_out, 0);

    // Async reset in DONE
    send(5'b01111); send(5'b01111); send(5'b01111); send(5'b01111);
    chk("t6c_valid", out_valid, 1);
    chk("t6c_data", digits_out, 16'h8888);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6c_async", out_valid, 0);
    chk("t6c_data0", digits_out, 0);
    chk("t6c_cnt0", digit_cnt, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6c_ready", code_ready, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
